// File: rtl/cnt_mod_param.sv
// cnt_mod_param: parametrised up/down event counter with programmable modulus.
// The terminal-count handling is selected at run time: wrap, saturate,
// auto-reload from the last loaded value, or one-shot stop.
// clr and load are synchronous. clr has priority over load, and load has
// priority over counting. cout is a registered one-cycle pulse that follows
// each terminal step.

module cnt_mod_param #(
  parameter int unsigned      W       = 16,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,      // asynchronous, active low
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic [W-1:0] mod_max,
  input  logic [1:0]   mode,
  output logic [W-1:0] dout,
  output logic         tc,
  output logic         cout,
  output logic         ovf,
  output logic         done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_RELOAD   = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_e;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] dout_reg, dout_next;
  logic [W-1:0] rld_reg,  rld_next;
  logic         cout_reg, cout_next;
  logic         ovf_reg,  ovf_next;
  logic         done_reg, done_next;
  logic         tc_int;
  mode_e        mode_sel;

  assign mode_sel = mode_e'(mode);

  // Terminal detect. The >= comparison also catches a dout that was loaded
  // above mod_max, or a mod_max that was lowered while counting.
  always_comb begin
    tc_int = 1'b0;
    if (up) tc_int = (dout_reg >= mod_max);
    else    tc_int = (dout_reg == '0);
  end

  // Next-state logic. Priority is clr, then load, then count.
  // A finished one-shot blocks counting only.
  always_comb begin
    dout_next = dout_reg;
    rld_next  = rld_reg;
    cout_next = 1'b0;
    ovf_next  = ovf_reg;
    done_next = done_reg;
    if (clr) begin
      dout_next = '0;
      ovf_next  = 1'b0;
      done_next = 1'b0;
    end else if (load) begin
      dout_next = ld_data;
      rld_next  = ld_data;
      ovf_next  = 1'b0;
      done_next = 1'b0;
    end else if (en && !done_reg) begin
      if (!tc_int) begin
        dout_next = up ? (dout_reg + ONE) : (dout_reg - ONE);
      end else begin
        case (mode_sel)
          MODE_WRAP: begin
            dout_next = up ? '0 : mod_max;
            cout_next = 1'b1;
          end
          MODE_SAT: begin
            ovf_next  = 1'b1;
          end
          MODE_RELOAD: begin
            dout_next = rld_reg;
            cout_next = 1'b1;
          end
          MODE_ONESHOT: begin
            done_next = 1'b1;
            cout_next = 1'b1;
          end
          default: begin
            dout_next = dout_reg;
          end
        endcase
      end
    end
  end

  // State registers. An asserted reset aborts any count immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_reg <= RST_VAL;
      rld_reg  <= RST_VAL;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      dout_reg <= dout_next;
      rld_reg  <= rld_next;
      cout_reg <= cout_next;
      ovf_reg  <= ovf_next;
      done_reg <= done_next;
    end
  end

  assign dout = dout_reg;
  assign tc   = tc_int;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_cnt_mod_param.sv
// Testbench for cnt_mod_param (W = 16). A behavioural reference model
// predicts every cycle. The prediction is queued when the inputs are driven.
// It is popped and compared after the clock edge. Constant end-of-sequence
// checks confirm the model against hand-derived values.

module tb_cnt_mod_param;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, up, clr, load;
  logic [W-1:0]  ld_data, mod_max;
  logic [1:0]    mode;
  logic [W-1:0]  dout;
  logic          tc, cout, ovf, done;

  cnt_mod_param #(.W(W), .RST_VAL('0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .ld_data(ld_data), .mod_max(mod_max), .mode(mode),
    .dout(dout), .tc(tc), .cout(cout), .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dout;
    logic         cout;
    logic         ovf;
    logic         done;
    logic         tc;
  } exp_t;

  exp_t sb_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cout_seen = 0;
  int cyc_no = 0;

  // reference model state
  logic [W-1:0] m_dout, m_rld;
  logic         m_cout, m_ovf, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      pass_cnt++;
  endtask

  task automatic model_reset();
    m_dout = '0; m_rld = '0; m_cout = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
  endtask

  // Advance the reference model by one clock edge using the given inputs.
  task automatic model_step(input logic e, input logic u, input logic c, input logic l,
                            input logic [W-1:0] ld, input logic [W-1:0] mm, input logic [1:0] md);
    logic at_term;
    m_cout = 1'b0;
    if (c) begin
      m_dout = '0; m_ovf = 1'b0; m_done = 1'b0;
    end else if (l) begin
      m_dout = ld; m_rld = ld; m_ovf = 1'b0; m_done = 1'b0;
    end else if (e && !m_done) begin
      at_term = u ? (m_dout >= mm) : (m_dout == 0);
      if (!at_term) begin
        m_dout = u ? W'(m_dout + 1) : W'(m_dout - 1);
      end else if (md == 2'b00) begin
        m_dout = u ? '0 : mm;
        m_cout = 1'b1;
      end else if (md == 2'b01) begin
        m_ovf = 1'b1;
      end else if (md == 2'b10) begin
        m_dout = m_rld;
        m_cout = 1'b1;
      end else begin
        m_done = 1'b1;
        m_cout = 1'b1;
      end
    end
  endtask

  // One clock transaction. Drive on the falling edge, predict and queue the
  // result, then compare after the rising edge.
  task automatic cyc(input logic e, input logic u, input logic c, input logic l,
                     input logic [W-1:0] ld, input logic [W-1:0] mm, input logic [1:0] md);
    exp_t ex, got;
    @(negedge clk);
    en = e; up = u; clr = c; load = l; ld_data = ld; mod_max = mm; mode = md;
    model_step(e, u, c, l, ld, mm, md);
    ex.dout = m_dout; ex.cout = m_cout; ex.ovf = m_ovf; ex.done = m_done;
    ex.tc = u ? (m_dout >= mm) : (m_dout == 0);
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    cyc_no++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check("dout", 32'(dout), 32'(got.dout));
      check("cout", 32'(cout), 32'(got.cout));
      check("ovf",  32'(ovf),  32'(got.ovf));
      check("done", 32'(done), 32'(got.done));
      check("tc",   32'(tc),   32'(got.tc));
    end
    if (cout) cout_seen++;
    $display("cyc %0d en=%0b up=%0b clr=%0b ld=%0b md=%0d dout=%0h tc=%0b cout=%0b ovf=%0b done=%0b",
             cyc_no, e, u, c, l, md, dout, tc, cout, ovf, done);
  endtask

  task automatic run(input int n, input logic u, input logic [W-1:0] mm, input logic [1:0] md);
    for (int i = 0; i < n; i++) cyc(1'b1, u, 1'b0, 1'b0, '0, mm, md);
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic u, input logic [W-1:0] mm, input logic [1:0] md);
    cyc(1'b0, u, 1'b0, 1'b1, v, mm, md);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    ld_data = '0; mod_max = 16'd9; mode = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_done", 32'(done), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 16'd9, 2'b00);

    // wrap, up, mod_max 9: 25 steps from 0
    cout_seen = 0;
    run(25, 1'b1, 16'd9, 2'b00);
    check("wrap_up_end", 32'(dout), 32'd5);
    check("wrap_up_pulses", 32'(cout_seen), 32'd2);

    // asynchronous reset while counting, dout = 5
    #2 rst = 1'b0;
    #1;
    check("arst_dout_now", 32'(dout), 32'd0);
    model_reset();
    @(posedge clk); #1;
    check("arst_held", 32'(dout), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // wrap, down, mod_max 4, load 2, 6 steps: 1,0,4,3,2,1
    do_load(16'd2, 1'b0, 16'd4, 2'b00);
    cout_seen = 0;
    run(6, 1'b0, 16'd4, 2'b00);
    check("wrap_dn_end", 32'(dout), 32'd1);
    check("wrap_dn_pulses", 32'(cout_seen), 32'd1);

    // saturate at FFFF, then clear
    do_load(16'hFFFE, 1'b1, 16'hFFFF, 2'b01);
    cout_seen = 0;
    run(4, 1'b1, 16'hFFFF, 2'b01);
    check("sat_dout", 32'(dout), 32'hFFFF);
    check("sat_ovf", 32'(ovf), 32'd1);
    check("sat_pulses", 32'(cout_seen), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, 16'hFFFF, 2'b01);
    check("sat_clr_ovf", 32'(ovf), 32'd0);

    // auto-reload down from 3, 9 steps, then reload value changed to 7
    do_load(16'd3, 1'b0, 16'd9, 2'b10);
    cout_seen = 0;
    run(9, 1'b0, 16'd9, 2'b10);
    check("rld_end", 32'(dout), 32'd2);
    check("rld_pulses", 32'(cout_seen), 32'd2);
    do_load(16'd7, 1'b0, 16'd9, 2'b10);
    run(8, 1'b0, 16'd9, 2'b10);
    check("rld7_end", 32'(dout), 32'd7);

    // one-shot up to 5
    do_load(16'd0, 1'b1, 16'd5, 2'b11);
    cout_seen = 0;
    run(10, 1'b1, 16'd5, 2'b11);
    check("os_dout", 32'(dout), 32'd5);
    check("os_done", 32'(done), 32'd1);
    check("os_pulses", 32'(cout_seen), 32'd1);
    do_load(16'd2, 1'b1, 16'd5, 2'b11);
    run(1, 1'b1, 16'd5, 2'b11);
    check("os_resume", 32'(dout), 32'd3);

    // clr beats load and en
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'd8, 16'd5, 2'b11);
    check("clr_prio", 32'(dout), 32'd0);

    // wrap with mod_max 0: stays 0, cout every cycle
    cout_seen = 0;
    run(4, 1'b1, 16'd0, 2'b00);
    check("mm0_pulses", 32'(cout_seen), 32'd4);

    // enable low: cout must drop
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 16'd0, 2'b00);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cnt_mod_param.md
Name: cnt_mod_param

Overview:
- Parametrised successor to the team's 16-bit load/enable counter.
- Features:
  - configurable width
  - programmable modulus
  - up/down direction
  - four terminal-count modes: wrap, saturate, auto-reload, one-shot
  - registered carry pulse, sticky overflow flag
- Used as a general event/tick counter and timebase generator inside the lab designs.
- Load is fully synchronous, so there is no combinational load/reset race.

Parameters:
- W, 16, counter, data and modulus width (2..32)
- RST_VAL, 0, value of dout and of the reload register after reset

Ports:
- clk      input   1   rising-edge clock
- rst      input   1   asynchronous active-low reset
- en       input   1   count enable, one step per cycle when high
- up       input   1   direction: 1 = increment, 0 = decrement
- clr      input   1   synchronous clear to 0
- load     input   1   synchronous load of ld_data
- ld_data  input   W   load value; also captured as the reload value
- mod_max  input   W   terminal value for up-counting (wrap point)
- mode     input   2   00 wrap, 01 saturate, 10 auto-reload, 11 one-shot
- dout     output  W   counter value (registered)
- tc       output  1   terminal-count indicator (combinational from state)
- cout     output  1   registered one-cycle carry/borrow pulse
- ovf      output  1   sticky saturation flag
- done     output  1   one-shot finished flag

Behaviour:
- Reset (rst low, asynchronous):
  - dout = RST_VAL, rld_q = RST_VAL
  - cout = 0, ovf = 0, done = 0
  - Asserting rst mid-count aborts the count immediately; a held rst overrides all inputs.
- Priority per clock edge: clr > load > en.
- clr:
  - dout = 0; cout, ovf and done cleared.
  - rld_q is unchanged.
- load:
  - dout = ld_data, rld_q = ld_data.
  - cout, ovf and done cleared.
  - Any value is accepted, including values above mod_max.
- tc (combinational):
  - When up = 1: tc = (dout >= mod_max). This covers out-of-range dout after a load or a mod_max change.
  - When up = 0: tc = (dout == 0).
- Count step: occurs when en = 1, clr = 0, load = 0 and done = 0.
  - tc = 0: dout +/- 1 modulo 2^W arithmetic. The result never crosses the terminal except via the tc = 1 rules below.
  - tc = 1, mode 00 (wrap):
    - up: dout <= 0
    - down: dout <= mod_max
    - cout <= 1
  - tc = 1, mode 01 (saturate):
    - dout holds
    - ovf <= 1 (sticky)
    - cout <= 0
  - tc = 1, mode 10 (auto-reload):
    - dout <= rld_q
    - cout <= 1
  - tc = 1, mode 11 (one-shot):
    - dout holds
    - done <= 1
    - cout <= 1
    - Further en is ignored until load or clr.
- cout:
  - High exactly one cycle, in the cycle after a terminal step.
  - Otherwise 0, including when en is low.
  - Consecutive terminal steps (e.g. mod_max = 0 in wrap mode) hold cout high for consecutive cycles.
- mod_max = 0, wrap, up: dout stays 0 and cout is high on every enabled cycle.
- Changing mode or up mid-count takes effect on the next edge; there is no pipeline.
- done only affects counting. clr and load are always honoured.
- Latency: dout updates on the edge where the step is sampled; tc follows combinationally.

Test Plan:
- rst low for 3 cycles, then high, en = 0 -> dout = 0, cout = ovf = done = 0. Assert rst asynchronously mid-count at dout = 5 -> dout = 0 immediately, before the next edge.
- W = 16, mode 00, up = 1, mod_max = 9, en = 1 for 25 cycles from 0 -> dout sequence 0..9,0..9,0..4. cout high in the cycles where dout = 0 after each wrap (2 pulses).
- mode 00, up = 0, mod_max = 4, load 2, en = 1 for 6 cycles -> dout sequence 2,1,0,4,3,2. One cout pulse, when dout becomes 4.
- mode 01, up = 1, mod_max = 16'hFFFF, load 16'hFFFE, en = 1 for 4 cycles -> dout = FFFF and holds; ovf = 1 from the cycle after the first terminal step. clr -> dout = 0, ovf = 0.
- mode 10, up = 0, load 3, en = 1 for 9 cycles -> dout sequence 3,2,1,0,3,2,1,0,3. cout pulses twice. Load 7 mid-sequence -> next reload uses 7.
- mode 11, up = 1, mod_max = 5, load 0, en = 1 for 10 cycles -> dout stops at 5, single cout pulse, done = 1. load 2 -> done = 0 and counting resumes. Simultaneous clr + load + en -> dout = 0.
